// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO burst reader: reader FSM encoding and
// default sizing that must agree with the upstream FIFO instance.
package fifo_pkg;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_BURST_LEN  = 8;
    localparam int DEFAULT_TIMEOUT    = 64;
    localparam int DEFAULT_FIFO_DEPTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } rd_state_e;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle between the upstream FIFO, the burst reader and the
// downstream consumer. The reader uses the master view.
interface fifo_burst_reader_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] fifo_data;
    logic             fifo_val;
    logic             fifo_almost_empty;
    logic             fifo_rdy;
    logic [WIDTH-1:0] out_data;
    logic             out_val;
    logic             out_last;
    logic             out_rdy;

    modport master (
        input  fifo_data, fifo_val, fifo_almost_empty, out_rdy,
        output fifo_rdy, out_data, out_val, out_last
    );

    modport slave (
        output fifo_data, fifo_val, fifo_almost_empty, out_rdy,
        input  fifo_rdy, out_data, out_val, out_last
    );

endinterface

// File: rtl/fifo_burst_reader.sv
// Pops words from a FIFO in fixed-length bursts, or in a short flush burst
// once the FIFO has sat non-empty but below the burst threshold for too long.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    fifo_burst_reader_if.master bus,
    output logic                busy
);

    localparam int IDX_W = $clog2(BURST_LEN);
    localparam int POP_W = IDX_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
    localparam logic [POP_W-1:0] POP_MAX  = POP_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    rd_state_e        state_q, state_d;
    logic [WIDTH-1:0] pend_data_q, pend_data_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic             pend_val_q, pend_val_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_val_q, out_val_d;
    logic [POP_W-1:0] pops_q, pops_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             busy_q, busy_d;

    logic active_s;
    logic out_free_s;
    logic pend_last_s;
    logic flush_dry_s;
    logic pop_s;
    logic out_load_s;
    logic load_last_s;

    assign active_s    = (state_q == ST_BURST) || (state_q == ST_FLUSH);
    assign out_free_s  = !out_val_q || bus.out_rdy;
    assign pend_last_s = pend_val_q && (pend_idx_q == LAST_IDX);
    assign flush_dry_s = (state_q == ST_FLUSH) && !bus.fifo_val;

    // PEND may refill only when it is empty or is handing its word to OUT this cycle.
    assign bus.fifo_rdy = active_s && (pops_q < POP_MAX) && (!pend_val_q || out_free_s);
    assign pop_s        = bus.fifo_val && bus.fifo_rdy;
    assign out_load_s   = pend_val_q && out_free_s && (pend_last_s || pop_s || flush_dry_s);
    // A word that moves without a successor being popped is the burst's final word.
    assign load_last_s  = pend_last_s || !pop_s;

    assign bus.out_data = out_data_q;
    assign bus.out_val  = out_val_q;
    assign bus.out_last = out_last_q;
    assign busy         = busy_q;

    // Next-state computation for the FSM, the PEND/OUT stages and the counters.
    always_comb begin
        state_d     = state_q;
        pend_data_d = pend_data_q;
        pend_idx_d  = pend_idx_q;
        pend_val_d  = pend_val_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_val_d   = out_val_q;
        pops_d      = pops_q;
        idle_cnt_d  = idle_cnt_q;

        if (pop_s) begin
            pend_data_d = bus.fifo_data;
            pend_idx_d  = pops_q[IDX_W-1:0];
            pend_val_d  = 1'b1;
            pops_d      = pops_q + POP_W'(1);
        end else if (out_load_s) begin
            pend_val_d  = 1'b0;
        end else begin
            pend_val_d  = pend_val_q;
        end

        if (out_load_s) begin
            out_data_d = pend_data_q;
            out_last_d = load_last_s;
            out_val_d  = 1'b1;
        end else if (out_val_q && bus.out_rdy) begin
            out_last_d = 1'b0;
            out_val_d  = 1'b0;
        end else begin
            out_val_d  = out_val_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.fifo_val && !bus.fifo_almost_empty) begin
                    state_d    = ST_BURST;
                    idle_cnt_d = '0;
                    pops_d     = '0;
                end else if (bus.fifo_val && (idle_cnt_q >= CNT_FIRE)) begin
                    state_d    = ST_FLUSH;
                    idle_cnt_d = '0;
                    pops_d     = '0;
                end else if (bus.fifo_val) begin
                    idle_cnt_d = (idle_cnt_q == CNT_SAT) ? idle_cnt_q : idle_cnt_q + CNT_W'(1);
                end else begin
                    idle_cnt_d = '0;
                end
            end
            ST_BURST, ST_FLUSH: begin
                if (out_load_s && load_last_s) begin
                    state_d = ST_DRAIN;
                end else if (flush_dry_s && (pops_q == '0)) begin
                    // FIFO emptied before the first pop: nothing to emit, give up cleanly.
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DRAIN: begin
                if (out_val_q && bus.out_rdy) begin
                    state_d    = ST_IDLE;
                    idle_cnt_d = '0;
                end else begin
                    state_d    = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset empties both stages and returns to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pend_data_q <= '0;
            pend_idx_q  <= '0;
            pend_val_q  <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_val_q   <= 1'b0;
            pops_q      <= '0;
            idle_cnt_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_data_q <= pend_data_d;
            pend_idx_q  <= pend_idx_d;
            pend_val_q  <= pend_val_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_val_q   <= out_val_d;
            pops_q      <= pops_d;
            idle_cnt_q  <= idle_cnt_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO feeds the reader, and a
// word-level scoreboard predicts data order and burst boundaries.
module tb_fifo_burst_reader;
    import fifo_pkg::*;

    localparam int WIDTH    = 32;
    localparam int BL       = 8;
    localparam int TO       = 64;
    localparam int DEPTH    = 32;
    localparam int AE_LEVEL = DEPTH / 4;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        full;
    } word_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy;

    fifo_burst_reader_if #(.WIDTH(WIDTH)) bus ();

    fifo_burst_reader #(.WIDTH(WIDTH), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master),
        .busy (busy)
    );

    always #5 clk = ~clk;

    logic [31:0] fq[$];
    word_t       exp_q[$];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int rdy_mode = 0;
    bit in_burst = 1'b0;
    bit flush_kind = 1'b0;
    int n_in_burst = 0;
    int rel_cyc = 0;
    bit chk_first_pop = 1'b0;
    int first_pop_exp = 0;
    int hs_last_cyc = 0;
    bit chk_restart = 1'b0;
    bit pushed037 = 1'b0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic prev_last = 1'b0;
    bit prev_last_hs = 1'b0;
    int hs_pos = 0;
    int hs_total = 0;
    int first_hs_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h cycle=%0d", tag, got, want, cyc);
        end
    endtask

    // One clock: drive at the start of the low phase, sample, then apply FIFO pops after the edge.
    task automatic step();
        logic  pop_now;
        logic  hs_now;
        logic  do_push;
        word_t w;
        cyc++;
        bus.fifo_val          = (fq.size() != 0);
        bus.fifo_data         = (fq.size() != 0) ? fq[0] : 32'd0;
        bus.fifo_almost_empty = (fq.size() < AE_LEVEL);
        case (rdy_mode)
            0: bus.out_rdy = 1'b1;
            1: bus.out_rdy = cyc[0];
            2: bus.out_rdy = ($urandom_range(0, 3) != 0);
            3: bus.out_rdy = !(bus.out_val && bus.out_last && !pushed037);
            default: bus.out_rdy = 1'b1;
        endcase
        #1;
        pop_now = bus.fifo_val && bus.fifo_rdy;
        hs_now  = bus.out_val && bus.out_rdy;
        do_push = (rdy_mode == 3) && bus.out_val && bus.out_last && !bus.out_rdy && !pushed037;

        if (prev_stall) begin
            check_eq("stall_val", 32'(bus.out_val), 32'd1);
            check_eq("stall_data", bus.out_data, prev_data);
            check_eq("stall_last", 32'(bus.out_last), 32'(prev_last));
        end
        if (prev_last_hs) check_eq("busy_gap", 32'(busy), 32'd0);
        if (bus.fifo_rdy) begin
            check_eq("rdy_busy", 32'(busy), 32'd1);
            if (bus.out_val && !bus.out_rdy) check_eq("rdy_both_full", 32'(exp_q.size() > 1), 32'd0);
        end

        if (hs_now) begin
            hs_total++;
            if (exp_q.size() == 0) begin
                check_eq("hs_outstanding", 32'(exp_q.size()), 32'd1);
            end else begin
                w = exp_q.pop_front();
                check_eq("data", bus.out_data, w.data);
                check_eq("last", 32'(bus.out_last), 32'(w.last));
                if (hs_pos == 0) first_hs_cyc = cyc;
                hs_pos++;
                if (w.last) begin
                    if (w.full && rdy_mode == 0) check_eq("throughput", 32'(cyc - first_hs_cyc), 32'(BL - 1));
                    if (rdy_mode == 3 && pushed037) begin
                        chk_restart = 1'b1;
                        hs_last_cyc = cyc;
                    end
                    hs_pos = 0;
                end
            end
        end

        if (pop_now) begin
            if (!in_burst) begin
                in_burst   = 1'b1;
                n_in_burst = 0;
                flush_kind = (fq.size() < AE_LEVEL);
            end
            n_in_burst++;
            w.data = fq[0];
            w.full = !flush_kind;
            w.last = (n_in_burst == BL) || (flush_kind && fq.size() == 1);
            if (w.last) in_burst = 1'b0;
            exp_q.push_back(w);
            if (chk_first_pop) begin
                check_eq("first_pop_lat", 32'(cyc - rel_cyc), 32'(first_pop_exp));
                chk_first_pop = 1'b0;
            end
            if (chk_restart) begin
                check_eq("idle_restart", 32'(cyc - hs_last_cyc), 32'(TO + 1));
                chk_restart = 1'b0;
            end
        end

        prev_stall   = bus.out_val && !bus.out_rdy;
        prev_data    = bus.out_data;
        prev_last    = bus.out_last;
        prev_last_hs = hs_now && bus.out_last;

        @(posedge clk);
        #1;
        if (pop_now) void'(fq.pop_front());
        if (do_push) begin
            fq.push_back(32'hA000_0001);
            fq.push_back(32'hA000_0002);
            pushed037 = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset(input int n, input int lat);
        reset = 1'b0;
        #1;
        check_eq("rst_out_val", 32'(bus.out_val), 32'd0);
        check_eq("rst_out_last", 32'(bus.out_last), 32'd0);
        check_eq("rst_out_data", bus.out_data, 32'd0);
        check_eq("rst_fifo_rdy", 32'(bus.fifo_rdy), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        in_burst     = 1'b0;
        hs_pos       = 0;
        prev_stall   = 1'b0;
        prev_last_hs = 1'b0;
        repeat (n) step();
        reset         = 1'b1;
        rel_cyc       = cyc;
        chk_first_pop = 1'b1;
        first_pop_exp = lat;
    endtask

    task automatic run_until_quiet(input int max_cyc);
        int k = 0;
        while ((fq.size() != 0 || busy || exp_q.size() != 0) && k < max_cyc) begin
            step();
            k++;
        end
        check_eq("quiet", 32'(fq.size() != 0 || busy || exp_q.size() != 0), 32'd0);
    endtask

    initial begin
        bus.fifo_data         = 32'd0;
        bus.fifo_val          = 1'b0;
        bus.fifo_almost_empty = 1'b1;
        bus.out_rdy           = 1'b1;
        @(negedge clk);

        // Two back-to-back full bursts of 0..15.
        rdy_mode = 0;
        for (int i = 0; i < 16; i++) fq.push_back(32'(i));
        apply_reset(2, 2);
        run_until_quiet(200);

        // Three words below the threshold: flush after the idle timeout.
        for (int i = 0; i < 3; i++) fq.push_back(32'h300 + 32'(i));
        apply_reset(2, TO + 1);
        run_until_quiet(300);

        // Full burst with the consumer stalling every other cycle.
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) fq.push_back(32'h500 + 32'(i));
        run_until_quiet(200);

        // Reset in the middle of a burst; the rest of the FIFO is read afresh.
        rdy_mode = 0;
        for (int i = 0; i < 16; i++) fq.push_back($urandom);
        hs_total = 0;
        for (int k = 0; k < 200 && hs_total < 4; k++) step();
        check_eq("mid_burst_hs", 32'(hs_total), 32'd4);
        apply_reset(2, 2);
        run_until_quiet(400);

        // One-word flush, two words arriving while its last word waits.
        rdy_mode  = 3;
        pushed037 = 1'b0;
        fq.push_back(32'h700);
        run_until_quiet(400);
        check_eq("restart_seen", 32'(pushed037), 32'd1);

        // Random fills and random consumer back-pressure.
        rdy_mode = 2;
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) fq.push_back($urandom);
            run_until_quiet(1500);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter WIDTH, 32, data word width; SHALL match the upstream FIFO WIDTH.
REQ-002 Parameter BURST_LEN, 8, words per full burst; SHALL be >=2 and <= upstream FIFO DEPTH/4.
REQ-003 Parameter TIMEOUT, 64, idle cycles with a non-empty FIFO before a flush burst; SHALL be >=1.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-006 fifo_data  in  WIDTH  FIFO head word.
REQ-007 fifo_val  in  1  FIFO non-empty.
REQ-008 fifo_almost_empty  in  1  FIFO occupancy below DEPTH/4.
REQ-009 fifo_rdy  out  1  pop request; a word is consumed when fifo_val && fifo_rdy.
REQ-010 out_data  out  WIDTH  burst word.
REQ-011 out_val  out  1  out_data valid.
REQ-012 out_last  out  1  final word of current burst; qualified by out_val.
REQ-013 out_rdy  in  1  downstream accept; transfer when out_val && out_rdy.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 Datapath SHALL be two registers: PEND (popped word + index + valid) and OUT (out_data, out_last, out_val).
REQ-016 States SHALL be IDLE, BURST, FLUSH, DRAIN.
REQ-017 IDLE->BURST when fifo_val && !fifo_almost_empty; idle counter cleared, word index cleared.
REQ-018 IDLE: idle counter increments each cycle fifo_val && fifo_almost_empty, clears when !fifo_val; IDLE->FLUSH when counter reaches TIMEOUT-1 with fifo_val high.
REQ-019 fifo_rdy SHALL be high only in BURST/FLUSH, while pops < BURST_LEN, and when PEND is empty or PEND moves to OUT that cycle; never high in IDLE/DRAIN.
REQ-020 OUT SHALL load from PEND when OUT is empty or out_rdy is high, and PEND holds index BURST_LEN-1 (out_last=1), or a new pop occurs (out_last=0), or state is FLUSH and fifo_val is low (out_last=1).
REQ-021 out_val, out_data, out_last SHALL stay stable while out_val && !out_rdy.
REQ-022 After the word with out_last=1 is loaded into OUT, state SHALL go to DRAIN; DRAIN->IDLE on the out_val && out_rdy handshake of that word.
REQ-023 A BURST SHALL always emit exactly BURST_LEN words; a FLUSH SHALL emit 1..BURST_LEN words, ending early when the FIFO runs empty.
REQ-024 Latency: word k appears on OUT the cycle after word k+1 is popped; the final word appears the cycle after it is popped (BURST) or the first cycle fifo_val is low after it is popped (FLUSH).
REQ-025 With out_rdy held high and fifo_val high, throughput SHALL be one word per cycle after the first.
REQ-026 Word index SHALL be $clog2(BURST_LEN) bits and SHALL never wrap within a burst; idle counter SHALL be $clog2(TIMEOUT)+1 bits, saturating.
REQ-027 Data order SHALL equal FIFO pop order; no word duplicated or dropped.

Reset
REQ-028 While reset is low: state IDLE, PEND and OUT empty, counters 0, out_val=0, out_last=0, out_data=0, fifo_rdy=0, busy=0.
REQ-029 Reset mid-burst SHALL discard PEND/OUT contents; words already popped are lost by definition.
REQ-030 Reset deassertion SHALL be synchronized by the integrator; the block makes no pop in the first cycle after release.

Structure
REQ-031 The state enum typedef SHALL live in the shared package fifo_pkg, alongside FIFO-related constants.
REQ-032 No sub-module is required; the block instantiates nothing and connects directly to a fifo instance.

Verification
REQ-033 BURST_LEN=8, FIFO preloaded with 16 words 0..15, out_rdy=1 -> two bursts 0..7 and 8..15, out_last on words 7 and 15, busy low between bursts.
REQ-034 3 words in FIFO, almost_empty=1, TIMEOUT=64 -> no pop for 63 cycles, then FLUSH of 3 words with out_last on the 3rd.
REQ-035 Full burst with out_rdy toggling 1/0 every cycle -> all 8 words in order, out_data/out_last stable during stalls, fifo_rdy never asserted with PEND and OUT both full.
REQ-036 Reset asserted after word 4 of a burst -> outputs 0 asynchronously, next burst starts at index 0 with correct out_last at the 8th word.
REQ-037 FLUSH with 1 word, then 2 words written during its DRAIN -> 1-word burst (out_last=1), then idle counter restarts from 0.
